// File: rtl/dual_ram_syn_param.sv
// Parametrised true dual-port synchronous RAM with byte-lane writes, selectable
// same-port read-during-write behaviour, optional output register and collision flag.
module dual_ram_syn_param #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned RD_MODE = 0,
  parameter int unsigned OUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en1,
  input  logic                  we1,
  input  logic [DATA_W/8-1:0]   be1,
  input  logic [ADDR_W-1:0]     addr1,
  input  logic [DATA_W-1:0]     din1,
  output logic [DATA_W-1:0]     dout1,
  output logic                  rvalid1,
  input  logic                  en2,
  input  logic                  we2,
  input  logic [DATA_W/8-1:0]   be2,
  input  logic [ADDR_W-1:0]     addr2,
  input  logic [DATA_W-1:0]     din2,
  output logic [DATA_W-1:0]     dout2,
  output logic                  rvalid2,
  output logic                  coll
);

  localparam int unsigned LANES = DATA_W / 8;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum int unsigned {
    RDW_NO_CHANGE   = 0,
    RDW_READ_FIRST  = 1,
    RDW_WRITE_FIRST = 2
  } rdw_e;

  localparam rdw_e MODE = rdw_e'(RD_MODE);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              en_a   [2];
  logic              we_a   [2];
  logic              wr_a   [2];
  logic [LANES-1:0]  be_a   [2];
  logic [ADDR_W-1:0] addr_a [2];
  logic [DATA_W-1:0] din_a  [2];

  logic [DATA_W-1:0] old_a  [2];
  logic [DATA_W-1:0] new_a  [2];

  logic [DATA_W-1:0] s1_d [2];
  logic [DATA_W-1:0] s1_q [2];
  logic              v1_d [2];
  logic              v1_q [2];
  logic [DATA_W-1:0] s2_q [2];
  logic              v2_q [2];

  logic coll_d, coll_q;

  assign en_a[0]   = en1;
  assign en_a[1]   = en2;
  assign we_a[0]   = we1;
  assign we_a[1]   = we2;
  assign be_a[0]   = be1;
  assign be_a[1]   = be2;
  assign addr_a[0] = addr1;
  assign addr_a[1] = addr2;
  assign din_a[0]  = din1;
  assign din_a[1]  = din2;
  assign wr_a[0]   = en1 & we1 & ~rst;
  assign wr_a[1]   = en2 & we2 & ~rst;

  // Post-write word as the array will hold it; applying port 2 last gives it lane priority.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      old_a[p] = mem_q[addr_a[p]];
      new_a[p] = old_a[p];
      for (int unsigned q = 0; q < 2; q++) begin
        if (wr_a[q] && (addr_a[q] == addr_a[p])) begin
          for (int unsigned l = 0; l < LANES; l++) begin
            if (be_a[q][l]) new_a[p][8*l +: 8] = din_a[q][8*l +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (wr_a[p]) begin
        for (int unsigned l = 0; l < LANES; l++) begin
          if (be_a[p][l]) mem_q[addr_a[p]][8*l +: 8] <= din_a[p][8*l +: 8];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      s1_d[p] = s1_q[p];
      v1_d[p] = 1'b0;
      if (en_a[p]) begin
        if (!we_a[p]) begin
          s1_d[p] = old_a[p];
          v1_d[p] = 1'b1;
        end else begin
          case (MODE)
            RDW_READ_FIRST: begin
              s1_d[p] = old_a[p];
              v1_d[p] = 1'b1;
            end
            RDW_WRITE_FIRST: begin
              s1_d[p] = new_a[p];
              v1_d[p] = 1'b1;
            end
            default: begin
              s1_d[p] = s1_q[p];
              v1_d[p] = 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign coll_d = en1 & en2 & (addr1 == addr2) & (we1 | we2);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned p = 0; p < 2; p++) begin
        s1_q[p] <= '0;
        v1_q[p] <= 1'b0;
        s2_q[p] <= '0;
        v2_q[p] <= 1'b0;
      end
      coll_q <= 1'b0;
    end else begin
      for (int unsigned p = 0; p < 2; p++) begin
        s1_q[p] <= s1_d[p];
        v1_q[p] <= v1_d[p];
        v2_q[p] <= v1_q[p];
        if (v1_q[p]) s2_q[p] <= s1_q[p];
      end
      coll_q <= coll_d;
    end
  end

  assign dout1   = (OUT_REG != 0) ? s2_q[0] : s1_q[0];
  assign rvalid1 = (OUT_REG != 0) ? v2_q[0] : v1_q[0];
  assign dout2   = (OUT_REG != 0) ? s2_q[1] : s1_q[1];
  assign rvalid2 = (OUT_REG != 0) ? v2_q[1] : v1_q[1];
  assign coll    = coll_q;

endmodule

// File: tb/tb_dual_ram_syn_param.sv
// Drives six RAM instances (every RD_MODE x OUT_REG) with identical traffic and
// checks them against a word-level memory model plus hand-computed expectations.
module tb_dual_ram_syn_param;

  logic        clk;
  logic        rst;
  logic        en_i [2];
  logic        we_i [2];
  logic [3:0]  be_i [2];
  logic [9:0]  ad_i [2];
  logic [31:0] di_i [2];

  logic [31:0] dout_w [6][2];
  logic        rv_w   [6][2];
  logic        coll_w [6];

  for (genvar g = 0; g < 6; g++) begin : g_dut
    dual_ram_syn_param #(
      .DATA_W (32),
      .ADDR_W (10),
      .RD_MODE(g % 3),
      .OUT_REG(g / 3)
    ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .en1    (en_i[0]),
      .we1    (we_i[0]),
      .be1    (be_i[0]),
      .addr1  (ad_i[0]),
      .din1   (di_i[0]),
      .dout1  (dout_w[g][0]),
      .rvalid1(rv_w[g][0]),
      .en2    (en_i[1]),
      .we2    (we_i[1]),
      .be2    (be_i[1]),
      .addr2  (ad_i[1]),
      .din2   (di_i[1]),
      .dout2  (dout_w[g][1]),
      .rvalid2(rv_w[g][1]),
      .coll   (coll_w[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 0;

  // Reference: array contents, plus the latency-1 view per mode; latency-2 is that view one cycle late.
  logic [31:0] mm  [1024];
  logic [31:0] e0d [3][2];
  logic        e0v [3][2];
  logic [31:0] e1d [3][2];
  logic        e1v [3][2];
  logic        ecoll;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic model_step();
    logic [31:0] old [2];
    if (rst) begin
      for (int m = 0; m < 3; m++)
        for (int p = 0; p < 2; p++) begin
          e0d[m][p] = '0; e0v[m][p] = 1'b0;
          e1d[m][p] = '0; e1v[m][p] = 1'b0;
        end
      ecoll = 1'b0;
    end else begin
      for (int p = 0; p < 2; p++) old[p] = mm[ad_i[p]];
      for (int p = 0; p < 2; p++)
        if (en_i[p] && we_i[p])
          for (int l = 0; l < 4; l++)
            if (be_i[p][l]) mm[ad_i[p]][8*l +: 8] = di_i[p][8*l +: 8];
      ecoll = en_i[0] && en_i[1] && (ad_i[0] == ad_i[1]) && (we_i[0] || we_i[1]);
      e1d = e0d;
      e1v = e0v;
      for (int m = 0; m < 3; m++)
        for (int p = 0; p < 2; p++) begin
          if (!en_i[p]) e0v[m][p] = 1'b0;
          else if (!we_i[p]) begin
            e0v[m][p] = 1'b1; e0d[m][p] = old[p];
          end else if (m == 0) e0v[m][p] = 1'b0;
          else if (m == 1) begin
            e0v[m][p] = 1'b1; e0d[m][p] = old[p];
          end else begin
            e0v[m][p] = 1'b1; e0d[m][p] = mm[ad_i[p]];
          end
        end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      for (int i = 0; i < 6; i++) begin
        for (int p = 0; p < 2; p++) begin
          chk($sformatf("dout i%0d p%0d", i, p + 1), dout_w[i][p],
              (i / 3 != 0) ? e1d[i % 3][p] : e0d[i % 3][p]);
          chk($sformatf("rvalid i%0d p%0d", i, p + 1), {31'd0, rv_w[i][p]},
              {31'd0, (i / 3 != 0) ? e1v[i % 3][p] : e0v[i % 3][p]});
        end
        chk($sformatf("coll i%0d", i), {31'd0, coll_w[i]}, {31'd0, ecoll});
      end
    end
  end

  task automatic setp(input int p, input logic e, input logic w, input logic [3:0] b,
                      input logic [9:0] a, input logic [31:0] d);
    en_i[p] = e; we_i[p] = w; be_i[p] = b; ad_i[p] = a; di_i[p] = d;
  endtask

  task automatic idle();
    setp(0, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    setp(1, 1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc();
    rst = 1'b0;
    // Fill every location so no read returns undefined data.
    for (int a = 0; a < 512; a++) begin
      setp(0, 1'b1, 1'b1, 4'hF, 10'(2 * a), $urandom);
      setp(1, 1'b1, 1'b1, 4'hF, 10'(2 * a + 1), $urandom);
      cyc();
    end
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk_en = 1;
    chk("reset dout1 i0", dout_w[0][0], 32'h0);
    chk("reset rvalid2 i5", {31'd0, rv_w[5][1]}, 32'h0);
    chk("reset coll i3", {31'd0, coll_w[3]}, 32'h0);
    cyc();

    // Write then read across ports
    setp(0, 1'b1, 1'b1, 4'hF, 10'h005, 32'h0000_00A5);
    cyc();
    idle();
    setp(1, 1'b1, 1'b0, 4'h0, 10'h005, 32'h0);
    cyc();
    chk("t1 dout2 i0", dout_w[0][1], 32'h0000_00A5);
    chk("t1 rvalid2 i0", {31'd0, rv_w[0][1]}, 32'h1);
    chk("t1 rvalid2 i3 early", {31'd0, rv_w[3][1]}, 32'h0);
    idle();
    cyc();
    chk("t1 dout2 i3", dout_w[3][1], 32'h0000_00A5);
    chk("t1 rvalid2 i3", {31'd0, rv_w[3][1]}, 32'h1);
    chk("t1 rvalid2 i0 idle", {31'd0, rv_w[0][1]}, 32'h0);
    chk("t1 dout2 i0 hold", dout_w[0][1], 32'h0000_00A5);

    // Byte lanes
    setp(0, 1'b1, 1'b1, 4'hF, 10'h009, 32'h1122_3344);
    cyc();
    setp(0, 1'b1, 1'b1, 4'b0101, 10'h009, 32'hFFFF_FFFF);
    cyc();
    setp(0, 1'b1, 1'b0, 4'h0, 10'h009, 32'h0);
    cyc();
    chk("t2 lanes i0", dout_w[0][0], 32'h11FF_33FF);

    // Same-port read-during-write
    setp(0, 1'b1, 1'b1, 4'hF, 10'h007, 32'h10);
    cyc();
    setp(0, 1'b1, 1'b0, 4'h0, 10'h009, 32'h0);
    cyc();
    setp(0, 1'b1, 1'b1, 4'hF, 10'h007, 32'h20);
    cyc();
    chk("t3 nochange dout", dout_w[0][0], 32'h11FF_33FF);
    chk("t3 nochange rvalid", {31'd0, rv_w[0][0]}, 32'h0);
    chk("t3 readfirst", dout_w[1][0], 32'h10);
    chk("t3 writefirst", dout_w[2][0], 32'h20);
    chk("t3 writefirst rvalid", {31'd0, rv_w[2][0]}, 32'h1);

    // Cross-port collisions
    setp(0, 1'b1, 1'b1, 4'hF, 10'h3FF, 32'h11);
    setp(1, 1'b1, 1'b1, 4'hF, 10'h3FF, 32'h22);
    cyc();
    chk("t4 coll ww i0", {31'd0, coll_w[0]}, 32'h1);
    chk("t4 coll ww i3", {31'd0, coll_w[3]}, 32'h1);
    setp(0, 1'b1, 1'b1, 4'hF, 10'h3FF, 32'h33);
    setp(1, 1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0);
    cyc();
    chk("t4 wr-rd dout2 i0", dout_w[0][1], 32'h22);
    chk("t4 wr-rd dout2 i2", dout_w[2][1], 32'h22);
    chk("t4 coll wr i1", {31'd0, coll_w[1]}, 32'h1);
    setp(0, 1'b1, 1'b0, 4'h0, 10'h3FF, 32'h0);
    setp(1, 1'b1, 1'b1, 4'hF, 10'h3FE, 32'h44);
    cyc();
    chk("t4 no coll diff addr", {31'd0, coll_w[0]}, 32'h0);
    chk("t4 final word", dout_w[0][0], 32'h33);
    idle();

    // Output-register pipeline and mid-stream reset
    for (int k = 1; k <= 3; k++) begin
      setp(0, 1'b1, 1'b1, 4'hF, 10'(k), 32'hA0 + 32'(k));
      cyc();
    end
    setp(0, 1'b1, 1'b0, 4'h0, 10'h001, 32'h0);
    cyc();
    chk("t5 rvalid i3 lat", {31'd0, rv_w[3][0]}, 32'h0);
    for (int k = 2; k <= 4; k++) begin
      setp(0, 1'b1, 1'b0, 4'h0, 10'(k == 4 ? 1 : k), 32'h0);
      cyc();
      chk($sformatf("t5 order %0d", k - 1), dout_w[3][0], 32'hA0 + 32'(k - 1));
      chk($sformatf("t5 rvalid %0d", k - 1), {31'd0, rv_w[3][0]}, 32'h1);
    end
    setp(0, 1'b1, 1'b0, 4'h0, 10'h002, 32'h0);
    cyc();
    rst = 1'b1;
    setp(0, 1'b1, 1'b0, 4'h0, 10'h003, 32'h0);
    setp(1, 1'b1, 1'b1, 4'hF, 10'h002, 32'hDEAD);
    cyc();
    rst = 1'b0;
    chk("t5 rst dout i3", dout_w[3][0], 32'h0);
    chk("t5 rst rvalid i3", {31'd0, rv_w[3][0]}, 32'h0);
    chk("t5 rst dout i0", dout_w[0][0], 32'h0);
    idle();
    cyc();
    chk("t5 no stale rvalid", {31'd0, rv_w[3][0]}, 32'h0);
    setp(0, 1'b1, 1'b0, 4'h0, 10'h002, 32'h0);
    cyc();
    idle();
    cyc();
    chk("t5 preserved", dout_w[3][0], 32'hA2);
    chk("t5 preserved rvalid", {31'd0, rv_w[3][0]}, 32'h1);

    // Random dual-port traffic, collisions encouraged by a narrow address window
    for (int c = 0; c < 10000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int p = 0; p < 2; p++) begin
        setp(p, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 4'($urandom),
             ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 7)) : 10'($urandom),
             $urandom);
      end
      cyc();
    end
    rst = 1'b0;
    idle();
    repeat (4) cyc();
    chk_en = 0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
